// File: rtl/md_pkg.sv
// Shared op-codes, FSM state encoding and op decode helpers for the HI/LO issue buffer.
package md_pkg;

  localparam int unsigned MD_OPW = 4;

  localparam logic [MD_OPW-1:0] MD_MULT  = 4'b0000;
  localparam logic [MD_OPW-1:0] MD_MULTU = 4'b0001;
  localparam logic [MD_OPW-1:0] MD_DIV   = 4'b0010;
  localparam logic [MD_OPW-1:0] MD_DIVU  = 4'b0011;
  localparam logic [MD_OPW-1:0] MD_MFHI  = 4'b0100;
  localparam logic [MD_OPW-1:0] MD_MFLO  = 4'b0101;
  localparam logic [MD_OPW-1:0] MD_MTHI  = 4'b0110;
  localparam logic [MD_OPW-1:0] MD_MTLO  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_SETTLE = 2'd3
  } md_state_e;

  // Only HI/LO-writing ops may enter the buffer; reads and reserved codes are dropped.
  function automatic logic md_is_legal(input logic [MD_OPW-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Moves complete in the write cycle and never occupy the unit.
  function automatic logic md_is_move(input logic [MD_OPW-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_buffer_if.sv
// Bundles the E-stage request side and the multiply/divide unit side of the issue buffer.
interface md_issue_buffer_if #(
  parameter int unsigned OPW = 4
) ();

  logic            req_valid;
  logic [OPW-1:0]  req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            req_ready;
  logic            rd_req;
  logic            stall;
  logic            md_wr;
  logic [OPW-1:0]  md_op;
  logic [31:0]     md_a;
  logic [31:0]     md_b;
  logic            md_busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rd_req, md_busy,
    output req_ready, stall, md_wr, md_op, md_a, md_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rd_req, md_busy,
    input  req_ready, stall, md_wr, md_op, md_a, md_b
  );

endinterface

// File: rtl/md_fifo.sv
// Small request FIFO (op + two operands) with occupancy count; pointers wrap modulo DEPTH.
module md_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 68
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Protect the count against a misbehaving producer or consumer.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/md_issue_buffer.sv
// Buffers HI/LO-writing ops from E and issues them one at a time to the mult/div unit;
// stalls mfhi/mflo while any earlier HI/LO work is still pending.
module md_issue_buffer
  import md_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OPW   = 4
) (
  input  logic                clk,
  input  logic                reset,
  md_issue_buffer_if.slave    bus
);

  localparam int unsigned W  = OPW + 64;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            push, pop;
  logic [W-1:0]    head;
  logic [OPW-1:0]  head_op;
  logic [31:0]     head_a, head_b;
  logic [CW-1:0]   count;
  logic            full, empty;

  md_state_e       state_q, state_d;
  logic            md_wr_q, md_wr_d;
  logic [OPW-1:0]  md_op_q, md_op_d;
  logic [31:0]     md_a_q, md_a_d;
  logic [31:0]     md_b_q, md_b_d;

  assign bus.req_ready = !full;
  assign push = bus.req_valid && !full && md_is_legal(bus.req_op);
  assign {head_op, head_a, head_b} = head;

  md_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.req_op, bus.req_a, bus.req_b}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = md_is_move(md_op_q) ? ST_IDLE : ST_BUSY;
      ST_BUSY:   if (!bus.md_busy) state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Operand registers hold their last value; only md_wr qualifies them.
  always_comb begin
    pop     = 1'b0;
    md_wr_d = 1'b0;
    md_op_d = md_op_q;
    md_a_d  = md_a_q;
    md_b_d  = md_b_q;
    if ((state_q == ST_IDLE) && !empty) begin
      pop     = 1'b1;
      md_wr_d = 1'b1;
      md_op_d = head_op;
      md_a_d  = head_a;
      md_b_d  = head_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_wr_q <= 1'b0;
      md_op_q <= '0;
      md_a_q  <= '0;
      md_b_q  <= '0;
    end else begin
      md_wr_q <= md_wr_d;
      md_op_q <= md_op_d;
      md_a_q  <= md_a_d;
      md_b_q  <= md_b_d;
    end
  end

  assign bus.md_wr = md_wr_q;
  assign bus.md_op = md_op_q;
  assign bus.md_a  = md_a_q;
  assign bus.md_b  = md_b_q;

  // Held low during reset even if the independently reset unit still reports busy.
  assign bus.stall = reset && bus.rd_req &&
                     ((count != '0) || (state_q != ST_IDLE) || bus.md_busy);

endmodule

// File: tb/tb_md_issue_buffer.sv
// Scoreboard bench for md_issue_buffer: models the mult/div unit, queues expected issues on
// acceptance and checks issue order, ready, stall and the resulting HI/LO contents.
module tb_md_issue_buffer;
  import md_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned OPW   = 4;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_issue_buffer_if #(.OPW(OPW)) bus ();

  md_issue_buffer #(
    .DEPTH (DEPTH),
    .OPW   (OPW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  req_t        exp_q[$];
  int          issue_cyc[$];
  int          accepted = 0;
  int          issued = 0;
  int          cyc = 0;
  int          nr_count = 0;
  bit          acc_last = 1'b0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  logic        u_busy;
  int          u_cnt;
  logic [31:0] u_hi, u_lo;
  logic [63:0] u_res;

  logic        prev_wr = 1'b0, prev_busy = 1'b0;
  int          tail = 0;

  assign bus.md_busy = u_busy;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Architectural HI/LO effect of one op, returned as {hi, lo}.
  function automatic logic [63:0] hilo_next(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    logic signed [63:0] sa, sb, sp;
    logic signed [31:0] qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    case (op)
      MD_MULT:  begin sp = sa * sb; return sp; end
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      MD_DIV:   return {32'(qa % qb), 32'(qa / qb)};
      MD_DIVU:  return {a % b, a / b};
      MD_MTHI:  return {a, lo};
      MD_MTLO:  return {hi, a};
      default:  return {hi, lo};
    endcase
  endfunction

  // Mult/div unit: samples md_wr, busy 5 cycles for mult, 10 for div, writes HI/LO on busy fall.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
      u_hi   <= '0;
      u_lo   <= '0;
      u_res  <= '0;
    end else if (bus.md_wr) begin
      if (bus.md_op == MD_MTHI || bus.md_op == MD_MTLO) begin
        {u_hi, u_lo} <= hilo_next(bus.md_op, bus.md_a, bus.md_b, u_hi, u_lo);
      end else begin
        u_res  <= hilo_next(bus.md_op, bus.md_a, bus.md_b, u_hi, u_lo);
        u_busy <= 1'b1;
        u_cnt  <= (bus.md_op == MD_DIV || bus.md_op == MD_DIVU) ? 10 : 5;
      end
    end else if (u_busy) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        u_busy       <= 1'b0;
        {u_hi, u_lo} <= u_res;
      end
    end
  end

  // Acceptance recorder: expected issue and reference HI/LO are produced at the handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      exp_q.delete();
      accepted <= 0;
      mdl_hi   <= '0;
      mdl_lo   <= '0;
      acc_last <= 1'b0;
    end else if (bus.req_valid && bus.req_ready && md_is_legal(bus.req_op)) begin
      exp_q.push_back('{op: bus.req_op, a: bus.req_a, b: bus.req_b});
      accepted          <= accepted + 1;
      {mdl_hi, mdl_lo}  <= hilo_next(bus.req_op, bus.req_a, bus.req_b, mdl_hi, mdl_lo);
      acc_last          <= 1'b1;
    end else begin
      acc_last <= 1'b0;
    end
  end

  req_t e;
  int   fc;
  int   t;

  // Monitor: pending HI/LO work = queued ops, the issue cycle, unit busy, and the two cycles
  // after busy falls (unit-done observation plus the settle cycle).
  always @(negedge clk) begin
    if (!reset) begin
      issued    <= 0;
      prev_wr   <= 1'b0;
      prev_busy <= 1'b0;
      tail      <= 0;
    end else begin
      t = tail;
      if (prev_busy && !bus.md_busy) t = 2;
      fc = accepted - issued - (bus.md_wr ? 1 : 0);
      if (bus.md_wr) begin
        chk("wr_pulse_single", prev_wr, 0);
        chk("issue_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("issue_op", bus.md_op, e.op);
          chk("issue_a", bus.md_a, e.a);
          chk("issue_b", bus.md_b, e.b);
        end
        issue_cyc.push_back(cyc);
      end
      chk("req_ready", bus.req_ready, fc < int'(DEPTH));
      chk("stall", bus.stall, bus.rd_req && (fc > 0 || bus.md_wr || bus.md_busy || t > 0));
      if (bus.rd_req && !bus.stall) begin
        chk("read_hi", u_hi, mdl_hi);
        chk("read_lo", u_lo, mdl_lo);
      end
      if (!bus.req_ready) nr_count <= nr_count + 1;
      issued    <= issued + (bus.md_wr ? 1 : 0);
      prev_wr   <= bus.md_wr;
      prev_busy <= bus.md_busy;
      tail      <= (t > 0) ? t - 1 : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted; returns one tick after the accepting edge with valid low.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    for (int i = 0; i < 60; i++) begin
      step();
      if (acc_last) begin
        ok = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  // Present an mfhi/mflo until the stall releases, bounded.
  task automatic read_wait();
    bit ok = 1'b0;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!bus.stall) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("read_release", ok, 1);
    @(negedge clk);
    step();
    bus.rd_req = 1'b0;
  endtask

  initial begin
    int nr_before;
    int n;
    bit seen;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rd_req    = 1'b1;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_md_wr", bus.md_wr, 0);
    chk("rst_md_op", bus.md_op, 0);
    chk("rst_md_a", bus.md_a, 0);
    chk("rst_md_b", bus.md_b, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_stall", bus.stall, 0);
    step();
    reset      = 1'b1;
    bus.rd_req = 1'b0;

    // Reset mid-BUSY with a second op still queued: both must be discarded.
    send(MD_MULT, 32'd9, 32'd9);
    send(MD_MULTU, 32'd4, 32'd4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.md_busy) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("t1_busy_seen", seen, 1);
    reset      = 1'b0;
    bus.rd_req = 1'b1;
    #1;
    chk("t1_md_wr", bus.md_wr, 0);
    chk("t1_ready", bus.req_ready, 1);
    chk("t1_stall", bus.stall, 0);
    step();
    reset = 1'b1;
    #1;
    chk("t1_idle_stall", bus.stall, 0);
    step();
    bus.rd_req = 1'b0;
    repeat (3) step();

    // mult 3 * -2, then mfhi the next cycle.
    send(MD_MULT, 32'd3, 32'hFFFF_FFFE);
    read_wait();
    chk("t2_hi", u_hi, 32'hFFFF_FFFF);
    chk("t2_lo", u_lo, 32'hFFFF_FFFA);

    // mthi/mtlo back-to-back, then mflo.
    send(MD_MTHI, 32'd5, 32'd0);
    send(MD_MTLO, 32'd7, 32'd0);
    read_wait();
    n = issue_cyc.size();
    chk("t3_issue_gap", issue_cyc[n-1] - issue_cyc[n-2], 2);
    chk("t3_hi", u_hi, 32'd5);
    chk("t3_lo", u_lo, 32'd7);

    // divu followed by two mults: buffer fills, order preserved, mult waits for div settle.
    nr_before = nr_count;
    send(MD_DIVU, 32'd100, 32'd7);
    send(MD_MULT, 32'd6, 32'd7);
    send(MD_MULTU, 32'd11, 32'd13);
    read_wait();
    n = issue_cyc.size();
    chk("t4_ready_dropped", nr_count > nr_before, 1);
    chk("t4_div_to_mult", issue_cyc[n-2] - issue_cyc[n-3], 14);
    chk("t4_lo", u_lo, 32'd143);

    // Illegal op is dropped silently.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b0100;
    bus.req_a     = 32'd1;
    bus.req_b     = 32'd1;
    step();
    bus.req_valid = 1'b0;
    bus.rd_req    = 1'b1;
    #1;
    chk("t5_stall", bus.stall, 0);
    chk("t5_ready", bus.req_ready, 1);
    step();
    bus.rd_req = 1'b0;

    // Randomized traffic, including illegal ops and interleaved reads; wraps the pointers.
    for (int i = 0; i < 500; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (rop[3:1] == 3'b001 && (rb == 32'd0 || rb == 32'hFFFF_FFFF)) rb = 32'd3;
      bus.req_valid = ($urandom_range(0, 1) == 1);
      bus.req_op    = rop;
      bus.req_a     = ra;
      bus.req_b     = rb;
      bus.rd_req    = ($urandom_range(0, 4) == 0);
      step();
    end
    bus.req_valid = 1'b0;
    bus.rd_req    = 1'b0;
    read_wait();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
